// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: the scoreboard entry layout,
// the EX operand-source encodings and the register-match helper.
package pipeline_hazard_unit_pkg;

    // Register IDs are stored zero-extended to this width, so ID_LENGTH may be at most 8.
    localparam int RID_W = 8;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic [RID_W-1:0] rd;
        logic             is_load;
        logic             sets_flags;
        logic [RID_W-1:0] rs1;
        logic             rs1_used;
        logic [RID_W-1:0] rs2;
        logic             rs2_used;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // A stage only produces a register if it holds a real instruction that writes the RF.
    function automatic logic sb_writes(input sb_entry_t e, input logic [RID_W-1:0] r);
        return e.valid & e.wr_en & (e.rd == r);
    endfunction

endpackage

// File: rtl/pipeline_hazard_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard controller for the 5-stage 8-bit datapath: tracks EX/MEM/WB in a private
// scoreboard and produces stall, flush and registered EX forwarding controls.
module pipeline_hazard_unit #(
    parameter int unsigned ID_LENGTH    = 3,
    parameter bit          FWD_EN       = 1'b1,
    parameter int unsigned BRANCH_STAGE = 1,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [ID_LENGTH-1:0] id_rs1,
    input  logic [ID_LENGTH-1:0] id_rs2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic [ID_LENGTH-1:0] id_rd,
    input  logic                 id_wr_en,
    input  logic                 id_is_load,
    input  logic                 id_sets_flags,
    input  logic                 id_uses_flags,
    input  logic                 branch_taken,
    output logic                 pc_ld,
    output logic                 pr1_ld,
    output logic                 pr1_flush,
    output logic                 pr2_flush,
    output logic [1:0]           fwd_sel_a,
    output logic [1:0]           fwd_sel_b,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    import pipeline_hazard_unit_pkg::*;

    sb_entry_t sb_ex_q, sb_mem_q, sb_wb_q;
    sb_entry_t sb_ex_d;
    fwd_sel_t  fwd_a_q, fwd_b_q;
    fwd_sel_t  fwd_a_d, fwd_b_d;

    logic [RID_W-1:0] rs1_x, rs2_x, rd_x;
    logic             use1, use2;
    logic             ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    logic             load_use, raw_nofwd, flag_haz, hazard;
    logic             stall, kill_id, branch_eff;

    assign rs1_x = RID_W'(id_rs1);
    assign rs2_x = RID_W'(id_rs2);
    assign rd_x  = RID_W'(id_rd);

    assign use1 = id_valid & id_rs1_used;
    assign use2 = id_valid & id_rs2_used;

    assign ex_hit1  = use1 & sb_writes(sb_ex_q,  rs1_x);
    assign ex_hit2  = use2 & sb_writes(sb_ex_q,  rs2_x);
    assign mem_hit1 = use1 & sb_writes(sb_mem_q, rs1_x);
    assign mem_hit2 = use2 & sb_writes(sb_mem_q, rs2_x);
    assign wb_hit1  = use1 & sb_writes(sb_wb_q,  rs1_x);
    assign wb_hit2  = use2 & sb_writes(sb_wb_q,  rs2_x);

    // Without forwarding, WB still blocks: the RF only takes the value at the clock edge.
    always_comb begin
        load_use  = 1'b0;
        raw_nofwd = 1'b0;
        if (FWD_EN) begin
            load_use = sb_ex_q.is_load & (ex_hit1 | ex_hit2);
        end else begin
            raw_nofwd = ex_hit1 | ex_hit2 | mem_hit1 | mem_hit2 | wb_hit1 | wb_hit2;
        end
        flag_haz = id_valid & id_uses_flags & sb_ex_q.valid & sb_ex_q.sets_flags;
        hazard   = load_use | raw_nofwd | flag_haz;
    end

    // A branch resolved in EX kills whatever sits in ID, so that instruction must not stall.
    always_comb begin
        if (BRANCH_STAGE == 2) begin
            kill_id    = branch_taken;
            stall      = hazard & ~branch_taken;
            branch_eff = branch_taken;
            pr2_flush  = stall | branch_taken;
        end else begin
            kill_id    = 1'b0;
            stall      = hazard;
            branch_eff = branch_taken & ~hazard;
            pr2_flush  = stall;
        end
        pr1_flush = branch_eff;
        pc_ld     = ~stall;
        pr1_ld    = ~stall;
    end

    always_comb begin
        sb_ex_d = SB_EMPTY;
        if (id_valid & ~stall & ~kill_id) begin
            sb_ex_d.valid      = 1'b1;
            sb_ex_d.wr_en      = id_wr_en;
            sb_ex_d.rd         = rd_x;
            sb_ex_d.is_load    = id_is_load;
            sb_ex_d.sets_flags = id_sets_flags;
            sb_ex_d.rs1        = rs1_x;
            sb_ex_d.rs1_used   = id_rs1_used;
            sb_ex_d.rs2        = rs2_x;
            sb_ex_d.rs2_used   = id_rs2_used;
        end
    end

    // Current EX becomes MEM next cycle and current MEM becomes WB; the younger one wins.
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (FWD_EN && sb_ex_d.valid) begin
            if (ex_hit1) begin
                fwd_a_d = FWD_MEM;
            end else if (mem_hit1) begin
                fwd_a_d = FWD_WB;
            end
            if (ex_hit2) begin
                fwd_b_d = FWD_MEM;
            end else if (mem_hit2) begin
                fwd_b_d = FWD_WB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_ex_q  <= SB_EMPTY;
            sb_mem_q <= SB_EMPTY;
            sb_wb_q  <= SB_EMPTY;
            fwd_a_q  <= FWD_RF;
            fwd_b_q  <= FWD_RF;
        end else begin
            sb_wb_q  <= sb_mem_q;
            sb_mem_q <= sb_ex_q;
            sb_ex_q  <= sb_ex_d;
            fwd_a_q  <= fwd_a_d;
            fwd_b_q  <= fwd_b_d;
        end
    end

    assign fwd_sel_a = fwd_a_q;
    assign fwd_sel_b = fwd_b_q;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (stall),
        .count_o (stall_count)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (pr1_flush),
        .count_o (flush_count)
    );

    // Source fields and the older stages' load/flag bits are kept for observability only.
    logic unused_sb;
    assign unused_sb = ^{sb_ex_q, sb_mem_q, sb_wb_q};

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
Central hazard controller for the 5-stage (IF, ID, EX, MEM, WB) 8-bit datapath. It tracks in-flight instructions in its own EX/MEM/WB scoreboard and generates the following controls:
- PC and IF/ID load enables (stall).
- IF/ID and ID/EX flushes (bubble or kill).
- Registered operand-forwarding selects for the EX stage.
- Stall and flush performance counters.

It is parametrised in register-ID width, branch-resolution stage and forwarding mode, and handles C/Z flag hazards.

Parameters:
ID_LENGTH, 3, register-ID width (RF has 2**ID_LENGTH entries)
FWD_EN, 1, 1 = forward from MEM/WB; 0 = stall until the producer has left WB
BRANCH_STAGE, 1, stage resolving taken branches: 1 = ID, 2 = EX
CNT_WIDTH, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
id_valid  in  1  ID holds a real instruction
id_rs1, id_rs2  in  ID_LENGTH  source register IDs
id_rs1_used, id_rs2_used  in  1  source actually read
id_rd  in  ID_LENGTH  destination register ID
id_wr_en  in  1  instruction writes the RF
id_is_load  in  1  instruction is a memory read
id_sets_flags  in  1  instruction updates C/Z in EX
id_uses_flags  in  1  instruction reads C/Z in ID (conditional branch)
branch_taken  in  1  taken branch/jump/ret resolved in BRANCH_STAGE
pc_ld  out  1  PC load enable
pr1_ld  out  1  IF/ID load enable
pr1_flush  out  1  clear IF/ID to NOP
pr2_flush  out  1  clear ID/EX to NOP (bubble)
fwd_sel_a, fwd_sel_b  out  2  EX operand source: 00 = RF, 01 = MEM (PR3 alu_out), 10 = WB (PR4 write data)
stall_count, flush_count  out  CNT_WIDTH  saturating event counters

Behaviour:
Reset:
- Scoreboard entries are invalid.
- fwd_sel_a and fwd_sel_b are 00; counters are 0.
- pc_ld = pr1_ld = 1 and flushes = 0 (combinational from the empty scoreboard).

Scoreboard:
- Three entries, EX, MEM and WB. Each holds {valid, wr_en, rd, is_load, sets_flags, rs1, rs1_used, rs2, rs2_used}.
- Each cycle MEM→WB and EX→MEM shift.
- EX loads the ID fields with valid = id_valid & ~stall & ~kill_id; otherwise it loads invalid (bubble).
- An entry only matches if it is valid and has wr_en = 1.

Hazards (ID, combinational, id_valid & rsX_used qualified):
- Load-use (FWD_EN = 1): the EX entry is a load whose rd equals a used rs → stall. Exactly 1 bubble.
- No forwarding (FWD_EN = 0): an EX, MEM or WB entry writes a used rs → stall. WB is included because the RF writes at the clock edge. Worst case is 3 consecutive stall cycles.
- Flag hazard: id_uses_flags and the EX entry has sets_flags → stall 1 cycle (C/Z update at the end of EX).
- stall = OR of the above.
- When stall = 1: pc_ld = 0, pr1_ld = 0, pr2_flush = 1.

Branch flush:
- branch_eff = branch_taken & ~stall. A branch in a stalled ID is ignored until it proceeds.
- BRANCH_STAGE = 1: pr1_flush = branch_eff (kills the IF instruction). 1 bubble.
- BRANCH_STAGE = 2: pr1_flush = pr2_flush = branch_taken, and kill_id = 1. stall is forced to 0 in that cycle, so pc_ld = 1: a killed instruction never stalls. 2 bubbles.

Forwarding (FWD_EN = 1):
- fwd_sel_a and fwd_sel_b are registered and aligned with the instruction entering EX.
- Computed from the ID sources against the entries that will be in MEM and WB next cycle, i.e. the current EX and MEM entries.
- Priority: the younger producer (EX→MEM) gives 01; else the MEM→WB producer gives 10; else 00.
- A source not used gives 00. A bubble entering EX gives 00.
- FWD_EN = 0: the selects are held at 00.

Counters:
- stall_count increments on every stall cycle.
- flush_count increments on every cycle with pr1_flush = 1.
- Both saturate at all-ones with no wrap.

Reset mid-stall: asynchronous reset clears the scoreboard immediately; pc_ld returns to 1 in the same cycle.

Decomposition:
- Shared package entry: typedef sb_entry_t (scoreboard struct); fwd_sel encodings FWD_RF, FWD_MEM, FWD_WB.
- One natural sub-module: sat_counter #(CNT_WIDTH), instantiated twice.

Test Plan:
- ADD r1 then SUB r2,r1,r3 back-to-back (FWD_EN = 1) → no stall; fwd_sel_a = 01 in the SUB EX cycle. With one NOP between them, fwd_sel_a = 10.
- LOAD r1 then ADD r2,r1,r1 → exactly 1 cycle with pc_ld = 0 and pr2_flush = 1; next cycle fwd_sel_a = fwd_sel_b = 10; stall_count = 1.
- FWD_EN = 0, ADD r1 then OR r4,r1,r0 → 3 stall cycles; OR enters EX with fwd_sel = 00; stall_count = 3.
- CMP (sets_flags) then conditional branch taken (BRANCH_STAGE = 1) → 1 stall, then pr1_flush = 1 for 1 cycle; flush_count = 1. Same case with BRANCH_STAGE = 2 and a load-use hazard in ID → branch_taken wins: pc_ld = 1 and pr1_flush = pr2_flush = 1.
- Assert rst low during a FWD_EN = 0 stall → pc_ld = 1 immediately; fwd_sel = 00; counters = 0. Preload a stalling sequence until stall_count reaches 2**CNT_WIDTH−1, then one more stall → counter holds.
